msx_slot_responder: RTL and testbench
=====================================

Name: msx_slot_responder

Overview:
- Cartridge-side responder for the MSX slot bus: the other end of the bus driven by msxbus.
- Synchronizes the asynchronous MSX strobes to the local clock and decodes memory cycles on its slot in 0x4000-0xBFFF.
- Implements an ASCII8 ROM mapper and serves reads from a local memory through a req/ack handshake.
- Holds the Z80 with nwait until read data is ready.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the strobe synchronizer (min 2).
- MEM_AW, 21, local memory byte-address width; bank register width is MEM_AW-13.
- TIMEOUT, 255, max clk cycles to wait for mem_ack before aborting a read.

Ports:
- clk  in  1  local clock.
- reset  in  1  synchronous, active-high reset.
- address  in  16  MSX address bus.
- data_in  in  8  MSX data bus, sampled on writes.
- data_out  out  8  byte driven onto the MSX data bus.
- data_oe  out  1  1 = drive data_out onto the bus.
- rd  in  1  MSX /RD, active low.
- wr  in  1  MSX /WR, active low.
- merq  in  1  MSX /MERQ, active low.
- sltsl  in  1  MSX /SLTSL for this slot, active low.
- msx_rst  in  1  MSX /RESET, active low.
- nwait  out  1  MSX /WAIT, active low; 1 = released.
- mem_addr  out  MEM_AW  local memory address.
- mem_req  out  1  read request, held high until ack.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  single-cycle acknowledge.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: the following apply on reset=1, or on synchronized msx_rst=0.
  - Outputs: data_out=0x00, data_oe=0, nwait=1, mem_req=0, mem_addr=0.
  - Internal: bank[0..3]=0, state=IDLE, timeout counter=0.
- Synchronization:
  - rd, wr, merq, sltsl and msx_rst pass through SYNC_STAGES flops. The synced values are used for all decisions.
  - address and data_in are captured in the cycle the cycle start is detected. They are already stable because the Z80 sets them before the strobes.
- Cycle start condition: synced sltsl=0 & merq=0 & (rd=0 xor wr=0) & address in 0x4000-0xBFFF.
- Page index: pidx = address[15:13]-2, giving 0..3.
- Mapped address: mem_addr = {bank[pidx], address[12:0]}.
- State IDLE:
  - Read start -> REQ. In the same transition: nwait=0, mem_req=1, mem_addr loaded, timeout counter cleared.
  - Write start with address in 0x6000-0x7FFF -> bank[address[12:11]] <= data_in, then -> DONE.
  - Any other write start -> DONE, with no effect.
  - Cycles outside the window, or with sltsl=1, are ignored.
- State REQ:
  - mem_ack=1 -> data_out<=mem_rdata, mem_req=0, data_oe=1, nwait=1, -> HOLD.
  - Counter reaches TIMEOUT without ack -> data_out<=0xFF, mem_req=0, data_oe=1, nwait=1, -> HOLD.
  - The counter saturates; it does not wrap.
- State HOLD: data_oe stays 1 until synced rd=1. Then data_oe=0 -> IDLE.
- State DONE: wait for synced wr=1 and merq=1 -> IDLE. This ensures one bank write per strobe.
- Read latency: nwait falls SYNC_STAGES+1 clks after rd falls. data_oe rises 1 clk after mem_ack.
- Simultaneous rd=0 and wr=0 (illegal): no cycle starts; stay IDLE.
- mem_ack in any state other than REQ is ignored.
- msx_rst or reset while in REQ: mem_req drops in the same clk edge. A late ack is ignored. Local memory must tolerate an abandoned request.
- Bank write during the same cycle as a read: not possible, since the FSM serializes cycles.
- Strobe released mid-REQ (rd=1 before ack):
  - Still complete the handshake.
  - HOLD sees rd=1 and returns to IDLE next clk.
  - data_oe pulses for at most 1 clk. This is acceptable because the bus is unsampled at that point.

Decomposition:
- Package msx_slot_pkg:
  - FSM state enum: IDLE, REQ, HOLD, DONE.
  - Constants: PAGE_LO=0x4000, PAGE_HI=0xBFFF, MAP_LO=0x6000, MAP_HI=0x7FFF, TIMEOUT_DATA=0xFF.
  - Helper function computing pidx.
- One sub-module: msx_sync, an N-stage synchronizer parameterized by width and SYNC_STAGES, reset value 1 (all strobes inactive-high).
- The FSM, bank registers and timeout counter live in msx_slot_responder.

Test Plan:
- Reset, then read 0x4000 with mem_rdata=0x3C and ack 5 clks after req.
  - nwait=0 at 3 clks after rd fall.
  - mem_addr=0x000000.
  - data_out=0x3C with data_oe=1 after ack; nwait=1.
  - data_oe=0 after rd rises (sync delay).
- Write 0x05 to 0x6800, then read 0x6123.
  - bank[1]=0x05.
  - mem_addr={0x05,0x0123}=0x0A123.
- Read 0xA000 with mem_ack never asserted.
  - nwait released and data_out=0xFF after TIMEOUT (255) clks.
  - mem_req=0.
- Reads with sltsl=1, and with address 0x0000 or 0xC000.
  - No mem_req, nwait stays 1, data_oe stays 0.
- Assert msx_rst=0 while in REQ, after prior bank writes of 0x12.
  - mem_req drops.
  - All banks=0.
  - Next read 0x8000 gives mem_addr=0x0000.
  - A late ack has no effect.
- Hold a write to 0x7800 (data 0x7F) for 20 clks with data_in changing mid-strobe.
  - bank[3]=0x7F, captured once.
  - Returns to IDLE only after wr and merq rise.

Source files
------------

// File: rtl/msx_slot_pkg.sv
// msx_slot_pkg: shared FSM states, address window constants and page index helper for the slot responder
package msx_slot_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;
  localparam logic [15:0] PAGE_LO = 16'h4000;
  localparam logic [15:0] PAGE_HI = 16'hBFFF;
  localparam logic [15:0] MAP_LO = 16'h6000;
  localparam logic [15:0] MAP_HI = 16'h7FFF;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
  function automatic logic [1:0] page_idx(input logic [15:0] a);
    return 2'(a[15:13] - 3'd2);
  endfunction
endpackage

// File: rtl/msx_sync.sv
// msx_sync: multi-stage synchronizer that resets to all ones so the active-low strobes start out idle
module msx_sync #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] ff [STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/msx_slot_responder.sv
// msx_slot_responder: MSX cartridge slot responder with an ASCII8 mapper serving reads from local memory
module msx_slot_responder
  import msx_slot_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_AW = 21,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       address,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic              rd,
  input  logic              wr,
  input  logic              merq,
  input  logic              sltsl,
  input  logic              msx_rst,
  output logic              nwait,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);
  localparam int BW = MEM_AW - 13;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic s_rd, s_wr, s_merq, s_sltsl, s_rst;
  msx_sync #(.W(5), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d({msx_rst, sltsl, merq, wr, rd}),
    .q({s_rst, s_sltsl, s_merq, s_wr, s_rd})
  );
  state_t state, state_n;
  logic [BW-1:0] bank [4];
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] data_out_n;
  logic data_oe_n, nwait_n, mem_req_n, bank_we, in_win, in_map, start;
  logic [MEM_AW-1:0] mem_addr_n;
  assign in_win = address >= PAGE_LO && address <= PAGE_HI;
  assign in_map = address >= MAP_LO && address <= MAP_HI;
  // exactly one of rd/wr low; both low is an illegal bus state and is ignored
  assign start = !s_sltsl && !s_merq && (s_rd ^ s_wr) && in_win;
  always_comb begin
    state_n = state;
    data_out_n = data_out;
    data_oe_n = data_oe;
    nwait_n = nwait;
    mem_req_n = mem_req;
    mem_addr_n = mem_addr;
    cnt_n = cnt;
    bank_we = 1'b0;
    case (state)
      IDLE: begin
        if (start && !s_rd) begin
          state_n = REQ;
          nwait_n = 1'b0;
          mem_req_n = 1'b1;
          mem_addr_n = {bank[page_idx(address)], address[12:0]};
          cnt_n = '0;
        end else if (start) begin
          state_n = DONE;
          bank_we = in_map;
        end
      end
      REQ: begin
        if (mem_ack || cnt == CW'(TIMEOUT)) begin
          state_n = HOLD;
          data_out_n = mem_ack ? mem_rdata : TIMEOUT_DATA;
          data_oe_n = 1'b1;
          nwait_n = 1'b1;
          mem_req_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (s_rd) begin
          data_oe_n = 1'b0;
          state_n = IDLE;
        end
      end
      DONE: state_n = (s_wr && s_merq) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || !s_rst) begin
      state <= IDLE;
      data_out <= 8'h00;
      data_oe <= 1'b0;
      nwait <= 1'b1;
      mem_req <= 1'b0;
      mem_addr <= '0;
      cnt <= '0;
      for (int i = 0; i < 4; i++) bank[i] <= '0;
    end else begin
      state <= state_n;
      data_out <= data_out_n;
      data_oe <= data_oe_n;
      nwait <= nwait_n;
      mem_req <= mem_req_n;
      mem_addr <= mem_addr_n;
      cnt <= cnt_n;
      if (bank_we) bank[address[12:11]] <= BW'(data_in);
    end
  end
endmodule

// File: tb/tb_msx_slot_responder.sv
// tb_msx_slot_responder: directed self-checking bench for the MSX slot responder
module tb_msx_slot_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] address = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic data_oe;
  logic rd = 1'b1, wr = 1'b1, merq = 1'b1, sltsl = 1'b1, msx_rst = 1'b1;
  logic nwait;
  logic [20:0] mem_addr;
  logic mem_req;
  logic [7:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  int tests = 0;
  int fails = 0;

  msx_slot_responder dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .rd(rd), .wr(wr), .merq(merq),
    .sltsl(sltsl), .msx_rst(msx_rst), .nwait(nwait), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_cycle(input logic [15:0] a, input logic is_rd, input logic [7:0] d);
    address = a;
    data_in = d;
    tick(1);
    merq = 1'b0;
    sltsl = 1'b0;
    if (is_rd) rd = 1'b0;
    else wr = 1'b0;
  endtask

  task automatic end_cycle();
    rd = 1'b1;
    wr = 1'b1;
    merq = 1'b1;
    sltsl = 1'b1;
    tick(4);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 10) begin
      tick(1);
      n++;
    end
    check(tag, mem_req, 1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    start_cycle(a, 1'b0, d);
    tick(3);
    end_cycle();
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [7:0] rdat,
                         output logic [20:0] ma, output logic [7:0] dout);
    start_cycle(a, 1'b1, 8'h00);
    wait_req(tag);
    ma = mem_addr;
    tick(2);
    mem_rdata = rdat;
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    dout = data_out;
    end_cycle();
  endtask

  logic [20:0] ma;
  logic [7:0] dout;
  logic [15:0] ign_a [4] = '{16'h4000, 16'h0000, 16'hC000, 16'h4000};
  logic ign_sl [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic ign_wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    tick(3);
    check("rst_nwait", nwait, 1);
    check("rst_oe", data_oe, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_dout", data_out, 8'h00);
    reset = 1'b0;
    tick(3);

    // basic read: latency of nwait, then ack 5 clks after req
    start_cycle(16'h4000, 1'b1, 8'h00);
    tick(2);
    check("lat_nwait_early", nwait, 1);
    tick(1);
    check("lat_nwait", nwait, 0);
    check("lat_req", mem_req, 1);
    check("rd0_addr", mem_addr, 21'h000000);
    tick(4);
    check("rd0_wait_held", nwait, 0);
    mem_rdata = 8'h3C;
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    check("rd0_dout", data_out, 8'h3C);
    check("rd0_oe", data_oe, 1);
    check("rd0_nwait", nwait, 1);
    check("rd0_req_drop", mem_req, 0);
    rd = 1'b1;
    merq = 1'b1;
    sltsl = 1'b1;
    tick(2);
    check("rd0_oe_hold", data_oe, 1);
    tick(1);
    check("rd0_oe_release", data_oe, 0);
    tick(2);

    // mapper write then mapped read
    do_write(16'h6800, 8'h05);
    do_read("rd1_req", 16'h6123, 8'h5A, ma, dout);
    check("rd1_addr", ma, 21'h0A123);
    check("rd1_dout", dout, 8'h5A);

    // timeout read
    start_cycle(16'hA000, 1'b1, 8'h00);
    wait_req("to_req");
    check("to_addr", mem_addr, 21'h000000);
    tick(250);
    check("to_nwait_held", nwait, 0);
    check("to_req_held", mem_req, 1);
    begin
      int n = 0;
      while (!nwait && n < 20) begin
        tick(1);
        n++;
      end
    end
    check("to_nwait", nwait, 1);
    check("to_dout", data_out, 8'hFF);
    check("to_oe", data_oe, 1);
    check("to_req", mem_req, 0);
    end_cycle();

    // cycles that must be ignored
    for (int i = 0; i < 4; i++) begin
      address = ign_a[i];
      tick(1);
      merq = 1'b0;
      sltsl = ign_sl[i];
      rd = 1'b0;
      wr = ign_wr[i];
      tick(6);
      check($sformatf("ign%0d_req", i), mem_req, 0);
      check($sformatf("ign%0d_nwait", i), nwait, 1);
      check($sformatf("ign%0d_oe", i), data_oe, 0);
      end_cycle();
    end

    // msx_rst during REQ clears banks and abandons the request
    do_write(16'h6000, 8'h12);
    do_write(16'h6800, 8'h12);
    do_write(16'h7000, 8'h12);
    do_write(16'h7800, 8'h12);
    do_read("pre_rst_req", 16'h8000, 8'h00, ma, dout);
    check("pre_rst_addr", ma, 21'h24000);
    start_cycle(16'h4000, 1'b1, 8'h00);
    wait_req("rst_req_seen");
    check("rst_req_addr", mem_addr, 21'h24000);
    msx_rst = 1'b0;
    begin
      int n = 0;
      while (mem_req && n < 6) begin
        tick(1);
        n++;
      end
    end
    check("msxrst_req", mem_req, 0);
    check("msxrst_nwait", nwait, 1);
    check("msxrst_addr", mem_addr, 0);
    end_cycle();
    msx_rst = 1'b1;
    tick(4);
    mem_rdata = 8'h99;
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    tick(1);
    check("late_ack_oe", data_oe, 0);
    check("late_ack_dout", data_out, 8'h00);
    check("late_ack_nwait", nwait, 1);
    do_read("post_rst_req", 16'h8000, 8'h11, ma, dout);
    check("post_rst_addr", ma, 21'h00000);
    check("post_rst_dout", dout, 8'h11);

    // long write strobe with data changing mid-strobe
    start_cycle(16'h7800, 1'b0, 8'h7F);
    tick(5);
    data_in = 8'h55;
    tick(15);
    check("lw_nwait", nwait, 1);
    wr = 1'b1;
    tick(4);
    rd = 1'b0;
    tick(6);
    check("lw_done_hold", mem_req, 0);
    end_cycle();
    do_read("lw_req", 16'hA000, 8'h77, ma, dout);
    check("lw_bank3", ma, 21'hFE000);
    check("lw_dout", dout, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
